// File: rtl/data_stack_if.sv
// data_stack_if
//   Bundles the command side and the status side of the operand stack.
//   The controller (master) issues one stack operation per cycle; the stack
//   (slave) reports its top two entries, depth and sticky error flags.
//
//   Signals:
//     i_en          perform i_op this cycle
//     i_op  [2:0]   0 NONE, 1 PUSH, 2 POP, 3 REPL, 4 SWAP, 5 DUP, 6 OVER, 7 RPL2
//     i_data        operand for PUSH, REPL and RPL2
//     o_s0          top of stack (0 when empty)
//     o_s1          next on stack (0 when fewer than two entries)
//     o_depth       current entry count
//     o_overflow    sticky, an entry was lost off the bottom
//     o_underflow   sticky, an op needed more entries than present
interface data_stack_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 12
);
    localparam int DEPTH_W = $clog2(DEPTH + 1);

    logic                 i_en;
    logic [2:0]           i_op;
    logic [WIDTH-1:0]     i_data;
    logic [WIDTH-1:0]     o_s0;
    logic [WIDTH-1:0]     o_s1;
    logic [DEPTH_W-1:0]   o_depth;
    logic                 o_overflow;
    logic                 o_underflow;

    modport master (
        output i_en,
        output i_op,
        output i_data,
        input  o_s0,
        input  o_s1,
        input  o_depth,
        input  o_overflow,
        input  o_underflow
    );

    modport slave (
        input  i_en,
        input  i_op,
        input  i_data,
        output o_s0,
        output o_s1,
        output o_depth,
        output o_overflow,
        output o_underflow
    );
endinterface

// File: rtl/data_stack.sv
// data_stack
//   Bounded LIFO operand stack feeding the ALU. TOS and NOS live in
//   dedicated registers so they can drive the ALU arguments directly; the
//   remaining entries live in a small circular array. A binary ALU op is
//   completed with RPL2, which removes TOS/NOS and pushes the ALU result.
//
//   Ports:
//     i_clk     system clock, rising edge
//     i_rst_n   asynchronous active-low reset
//     bus       data_stack_if slave modport (command in, stack status out)
module data_stack #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 12
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    data_stack_if.slave   bus
);
    localparam int DEPTH_W = $clog2(DEPTH + 1);
    // Entries 2..DEPTH-1 go into the array; keep at least one slot so the
    // declaration stays legal when DEPTH == 2 (HAS_MEM then disables it).
    localparam int MEM_N   = (DEPTH > 2) ? DEPTH - 2 : 1;
    localparam int PTR_W   = (MEM_N > 1) ? $clog2(MEM_N) : 1;
    localparam bit HAS_MEM = (DEPTH > 2);

    localparam logic [DEPTH_W-1:0] DEPTH_MAX = DEPTH_W'(DEPTH);
    localparam logic [DEPTH_W-1:0] D_ONE     = DEPTH_W'(1);
    localparam logic [DEPTH_W-1:0] D_TWO     = DEPTH_W'(2);
    localparam logic [DEPTH_W-1:0] D_THREE   = DEPTH_W'(3);
    localparam logic [PTR_W-1:0]   PTR_LAST  = PTR_W'(MEM_N - 1);
    localparam logic [PTR_W-1:0]   PTR_ONE   = PTR_W'(1);

    typedef enum logic [2:0] {
        OP_NONE = 3'd0,
        OP_PUSH = 3'd1,
        OP_POP  = 3'd2,
        OP_REPL = 3'd3,
        OP_SWAP = 3'd4,
        OP_DUP  = 3'd5,
        OP_OVER = 3'd6,
        OP_RPL2 = 3'd7
    } stack_op_e;

    logic [WIDTH-1:0]   s0_q, s0_d;
    logic [WIDTH-1:0]   s1_q, s1_d;
    logic [DEPTH_W-1:0] depth_q, depth_d;
    logic               overflow_q, overflow_d;
    logic               underflow_q, underflow_d;
    logic [PTR_W-1:0]   ptr_q;
    logic [PTR_W-1:0]   ptr_inc;
    logic [PTR_W-1:0]   ptr_dec;
    logic [WIDTH-1:0]   mem [MEM_N];

    stack_op_e          op;
    logic [DEPTH_W-1:0] need;
    logic [WIDTH-1:0]   push_val;
    logic [WIDTH-1:0]   deeper;
    logic               mem_push;
    logic               mem_pop;

    assign op = stack_op_e'(bus.i_op);

    // ptr_q points at the array's topmost entry. The array is circular:
    // when the stack is full, the slot after the top is the oldest entry,
    // so a push there is exactly the "deepest entry is lost" behaviour.
    assign ptr_inc = (ptr_q == PTR_LAST) ? '0 : ptr_q + PTR_ONE;
    assign ptr_dec = (ptr_q == '0) ? PTR_LAST : ptr_q - PTR_ONE;

    // Third entry, refilled into NOS when the stack shrinks; 0 when absent
    // so NOS reads 0 whenever fewer than two entries remain.
    assign deeper = (HAS_MEM && depth_q >= D_THREE) ? mem[ptr_q] : '0;

    always_comb begin
        s0_d        = s0_q;
        s1_d        = s1_q;
        depth_d     = depth_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        mem_push    = 1'b0;
        mem_pop     = 1'b0;
        need        = '0;
        push_val    = bus.i_data;

        case (op)
            OP_POP, OP_REPL, OP_DUP:  need = D_ONE;
            OP_SWAP, OP_OVER, OP_RPL2: need = D_TWO;
            default:                   need = '0;
        endcase

        case (op)
            OP_DUP:  push_val = s0_q;
            OP_OVER: push_val = s1_q;
            default: push_val = bus.i_data;
        endcase

        if (bus.i_en) begin
            if (depth_q < need) begin
                // Suppress the op entirely; only the sticky flag moves.
                underflow_d = 1'b1;
            end else begin
                case (op)
                    OP_PUSH, OP_DUP, OP_OVER: begin
                        s0_d = push_val;
                        s1_d = s0_q;
                        // Old NOS sinks into the array. With no array
                        // (DEPTH == 2) it simply falls off the bottom.
                        mem_push = HAS_MEM && (depth_q >= D_TWO);
                        if (depth_q == DEPTH_MAX) begin
                            overflow_d = 1'b1;
                        end else begin
                            depth_d = depth_q + D_ONE;
                        end
                    end
                    OP_POP: begin
                        s0_d    = s1_q;
                        s1_d    = deeper;
                        mem_pop = HAS_MEM && (depth_q >= D_THREE);
                        depth_d = depth_q - D_ONE;
                    end
                    OP_REPL: begin
                        s0_d = bus.i_data;
                    end
                    OP_SWAP: begin
                        s0_d = s1_q;
                        s1_d = s0_q;
                    end
                    OP_RPL2: begin
                        s0_d    = bus.i_data;
                        s1_d    = deeper;
                        mem_pop = HAS_MEM && (depth_q >= D_THREE);
                        depth_d = depth_q - D_ONE;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s0_q        <= '0;
            s1_q        <= '0;
            depth_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            ptr_q       <= PTR_LAST;
        end else begin
            s0_q        <= s0_d;
            s1_q        <= s1_d;
            depth_q     <= depth_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            if (mem_push) begin
                ptr_q <= ptr_inc;
            end else if (mem_pop) begin
                ptr_q <= ptr_dec;
            end
        end
    end

    // Array contents are don't-care after reset, so no reset term here.
    always_ff @(posedge i_clk) begin
        if (mem_push) begin
            mem[ptr_inc] <= s1_q;
        end
    end

    assign bus.o_s0        = s0_q;
    assign bus.o_s1        = s1_q;
    assign bus.o_depth     = depth_q;
    assign bus.o_overflow  = overflow_q;
    assign bus.o_underflow = underflow_q;

endmodule

// File: tb/tb_data_stack.sv
// tb_data_stack
//   Self-checking bench for data_stack: directed scenarios from the stack's
//   intended use (ALU loop, underflow, overflow, async reset) plus random
//   op sequences compared against a queue-based LIFO model.
module tb_data_stack;
    localparam int WIDTH = 8;
    localparam int DEPTH = 12;

    localparam logic [2:0] OP_NONE = 3'd0;
    localparam logic [2:0] OP_PUSH = 3'd1;
    localparam logic [2:0] OP_POP  = 3'd2;
    localparam logic [2:0] OP_REPL = 3'd3;
    localparam logic [2:0] OP_SWAP = 3'd4;
    localparam logic [2:0] OP_DUP  = 3'd5;
    localparam logic [2:0] OP_OVER = 3'd6;
    localparam logic [2:0] OP_RPL2 = 3'd7;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    data_stack_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    data_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: index 0 of the queue is TOS.
    logic [WIDTH-1:0] model_q[$];
    bit               model_of;
    bit               model_uf;

    function automatic void model_reset();
        model_q.delete();
        model_of = 1'b0;
        model_uf = 1'b0;
    endfunction

    function automatic void model_push(input logic [WIDTH-1:0] v);
        model_q.push_front(v);
        if (model_q.size() > DEPTH) begin
            void'(model_q.pop_back());
            model_of = 1'b1;
        end
    endfunction

    function automatic void model_apply(input logic en, input logic [2:0] op,
                                        input logic [WIDTH-1:0] d);
        int need;
        logic [WIDTH-1:0] t;
        if (!en) return;
        case (op)
            OP_POP, OP_REPL, OP_DUP:   need = 1;
            OP_SWAP, OP_OVER, OP_RPL2: need = 2;
            default:                   need = 0;
        endcase
        if (model_q.size() < need) begin
            model_uf = 1'b1;
            return;
        end
        case (op)
            OP_PUSH: model_push(d);
            OP_DUP:  begin t = model_q[0]; model_push(t); end
            OP_OVER: begin t = model_q[1]; model_push(t); end
            OP_POP:  void'(model_q.pop_front());
            OP_REPL: model_q[0] = d;
            OP_SWAP: begin
                t = model_q[0];
                model_q[0] = model_q[1];
                model_q[1] = t;
            end
            OP_RPL2: begin
                void'(model_q.pop_front());
                void'(model_q.pop_front());
                model_q.push_front(d);
            end
            default: ;
        endcase
    endfunction

    function automatic logic [WIDTH-1:0] model_s0();
        return (model_q.size() > 0) ? model_q[0] : '0;
    endfunction

    function automatic logic [WIDTH-1:0] model_s1();
        return (model_q.size() > 1) ? model_q[1] : '0;
    endfunction

    // Drive one op for a single edge, then park i_en low so idle cycles
    // never repeat it. Outputs are stable #1 after the sampling edge.
    task automatic drive_op(input logic en, input logic [2:0] op,
                            input logic [WIDTH-1:0] d);
        @(negedge clk);
        bus.i_en   = en;
        bus.i_op   = op;
        bus.i_data = d;
        @(posedge clk);
        #1;
        model_apply(en, op, d);
        bus.i_en = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        bus.i_en = 1'b0;
        rst_n    = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if (bus.o_s0 !== 8'h00) begin errors++; $display("[TB] FAIL reset_s0: got %h expected 00", bus.o_s0); end
        checks++;
        if (bus.o_s1 !== 8'h00) begin errors++; $display("[TB] FAIL reset_s1: got %h expected 00", bus.o_s1); end
        checks++;
        if (bus.o_depth !== 4'd0) begin errors++; $display("[TB] FAIL reset_depth: got %0d expected 0", bus.o_depth); end
        checks++;
        if (bus.o_overflow !== 1'b0 || bus.o_underflow !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_flags: got of=%b uf=%b expected 0 0", bus.o_overflow, bus.o_underflow);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_push_swap_over();
        drive_op(1'b1, OP_PUSH, 8'h11);
        drive_op(1'b1, OP_PUSH, 8'h22);
        drive_op(1'b1, OP_PUSH, 8'h33);
        checks++;
        if ({bus.o_s0, bus.o_s1} !== 16'h3322 || bus.o_depth !== 4'd3) begin
            errors++;
            $display("[TB] FAIL push3: got s0=%h s1=%h d=%0d expected 33 22 3", bus.o_s0, bus.o_s1, bus.o_depth);
        end
        checks++;
        if (bus.o_overflow !== 1'b0 || bus.o_underflow !== 1'b0) begin
            errors++;
            $display("[TB] FAIL push3_flags: got of=%b uf=%b expected 0 0", bus.o_overflow, bus.o_underflow);
        end
        drive_op(1'b1, OP_SWAP, 8'h00);
        checks++;
        if ({bus.o_s0, bus.o_s1} !== 16'h2233 || bus.o_depth !== 4'd3) begin
            errors++;
            $display("[TB] FAIL swap: got s0=%h s1=%h d=%0d expected 22 33 3", bus.o_s0, bus.o_s1, bus.o_depth);
        end
        drive_op(1'b1, OP_OVER, 8'h00);
        checks++;
        if ({bus.o_s0, bus.o_s1} !== 16'h3322 || bus.o_depth !== 4'd4) begin
            errors++;
            $display("[TB] FAIL over: got s0=%h s1=%h d=%0d expected 33 22 4", bus.o_s0, bus.o_s1, bus.o_depth);
        end
    endtask

    task automatic test_alu_loop();
        do_reset();
        drive_op(1'b1, OP_PUSH, 8'h05);
        drive_op(1'b1, OP_PUSH, 8'h03);
        checks++;
        if ({bus.o_s0, bus.o_s1} !== 16'h0305) begin
            errors++;
            $display("[TB] FAIL alu_args: got s0=%h s1=%h expected 03 05", bus.o_s0, bus.o_s1);
        end
        drive_op(1'b1, OP_NONE, 8'hEE);
        drive_op(1'b1, OP_RPL2, 8'h08);
        checks++;
        if (bus.o_s0 !== 8'h08 || bus.o_s1 !== 8'h00 || bus.o_depth !== 4'd1) begin
            errors++;
            $display("[TB] FAIL alu_rpl2: got s0=%h s1=%h d=%0d expected 08 00 1", bus.o_s0, bus.o_s1, bus.o_depth);
        end
        drive_op(1'b1, OP_POP, 8'h00);
        checks++;
        if (bus.o_s0 !== 8'h00 || bus.o_depth !== 4'd0) begin
            errors++;
            $display("[TB] FAIL alu_pop: got s0=%h d=%0d expected 00 0", bus.o_s0, bus.o_depth);
        end
    endtask

    task automatic test_underflow();
        do_reset();
        drive_op(1'b1, OP_POP, 8'h00);
        checks++;
        if (bus.o_depth !== 4'd0 || bus.o_underflow !== 1'b1) begin
            errors++;
            $display("[TB] FAIL uf_pop: got d=%0d uf=%b expected 0 1", bus.o_depth, bus.o_underflow);
        end
        drive_op(1'b1, OP_RPL2, 8'h99);
        checks++;
        if (bus.o_depth !== 4'd0 || bus.o_s0 !== 8'h00 || bus.o_underflow !== 1'b1) begin
            errors++;
            $display("[TB] FAIL uf_rpl2: got d=%0d s0=%h uf=%b expected 0 00 1", bus.o_depth, bus.o_s0, bus.o_underflow);
        end
        drive_op(1'b1, OP_PUSH, 8'h44);
        checks++;
        if (bus.o_s0 !== 8'h44 || bus.o_depth !== 4'd1 || bus.o_underflow !== 1'b1) begin
            errors++;
            $display("[TB] FAIL uf_sticky: got s0=%h d=%0d uf=%b expected 44 1 1", bus.o_s0, bus.o_depth, bus.o_underflow);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 1; i <= 13; i++) begin
            drive_op(1'b1, OP_PUSH, 8'(i));
        end
        checks++;
        if (bus.o_depth !== 4'd12 || bus.o_overflow !== 1'b1 || bus.o_s0 !== 8'd13) begin
            errors++;
            $display("[TB] FAIL of_push: got d=%0d of=%b s0=%0d expected 12 1 13", bus.o_depth, bus.o_overflow, bus.o_s0);
        end
        for (int i = 0; i < 11; i++) begin
            drive_op(1'b1, OP_POP, 8'h00);
        end
        checks++;
        if (bus.o_s0 !== 8'd2 || bus.o_s1 !== 8'd0 || bus.o_depth !== 4'd1) begin
            errors++;
            $display("[TB] FAIL of_lost: got s0=%0d s1=%0d d=%0d expected 2 0 1", bus.o_s0, bus.o_s1, bus.o_depth);
        end
        checks++;
        if (bus.o_overflow !== 1'b1 || bus.o_underflow !== 1'b0) begin
            errors++;
            $display("[TB] FAIL of_flags: got of=%b uf=%b expected 1 0", bus.o_overflow, bus.o_underflow);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive_op(1'b1, OP_PUSH, 8'hA1 + 8'(i));
        end
        drive_op(1'b1, OP_POP, 8'h00);
        drive_op(1'b1, OP_POP, 8'h00);
        drive_op(1'b1, OP_POP, 8'h00);
        drive_op(1'b1, OP_PUSH, 8'hB0);
        drive_op(1'b1, OP_PUSH, 8'hB1);
        drive_op(1'b1, OP_PUSH, 8'hB2);
        checks++;
        if (bus.o_depth !== 4'd5 || bus.o_s0 !== 8'hB2 || bus.o_s1 !== 8'hB1) begin
            errors++;
            $display("[TB] FAIL ar_pre: got d=%0d s0=%h s1=%h expected 5 b2 b1", bus.o_depth, bus.o_s0, bus.o_s1);
        end
        // Assert reset mid-cycle with a live PUSH on the bus.
        #2;
        bus.i_en   = 1'b1;
        bus.i_op   = OP_PUSH;
        bus.i_data = 8'h77;
        rst_n      = 1'b0;
        #1;
        checks++;
        if (bus.o_s0 !== 8'h00 || bus.o_s1 !== 8'h00 || bus.o_depth !== 4'd0) begin
            errors++;
            $display("[TB] FAIL ar_async: got s0=%h s1=%h d=%0d expected 00 00 0", bus.o_s0, bus.o_s1, bus.o_depth);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus.o_s0 !== 8'h00 || bus.o_depth !== 4'd0 || bus.o_overflow !== 1'b0 || bus.o_underflow !== 1'b0) begin
            errors++;
            $display("[TB] FAIL ar_hold: got s0=%h d=%0d of=%b uf=%b expected 00 0 0 0",
                     bus.o_s0, bus.o_depth, bus.o_overflow, bus.o_underflow);
        end
        @(negedge clk);
        bus.i_en = 1'b0;
        rst_n    = 1'b1;
        model_reset();
    endtask

    task automatic test_enable_low();
        do_reset();
        drive_op(1'b1, OP_PUSH, 8'h5A);
        drive_op(1'b0, OP_PUSH, 8'hC3);
        drive_op(1'b0, OP_SWAP, 8'h00);
        drive_op(1'b0, OP_POP, 8'h00);
        checks++;
        if (bus.o_s0 !== 8'h5A || bus.o_depth !== 4'd1 || bus.o_underflow !== 1'b0) begin
            errors++;
            $display("[TB] FAIL en_low: got s0=%h d=%0d uf=%b expected 5a 1 0", bus.o_s0, bus.o_depth, bus.o_underflow);
        end
    endtask

    // Back-to-back random ops, one per cycle, against the queue model.
    task automatic test_random();
        logic [2:0]       op;
        logic             en;
        logic [WIDTH-1:0] d;
        for (int round = 0; round < 4; round++) begin
            do_reset();
            for (int n = 0; n < 90; n++) begin
                op = 3'($urandom_range(0, 7));
                if (round == 1 && $urandom_range(0, 1) == 0) op = OP_PUSH;
                en = ($urandom_range(0, 9) != 0);
                d  = 8'($urandom);
                drive_op(en, op, d);
                checks++;
                if (bus.o_s0 !== model_s0() || bus.o_s1 !== model_s1()) begin
                    errors++;
                    $display("[TB] FAIL rand_tos: round %0d step %0d got %h %h expected %h %h",
                             round, n, bus.o_s0, bus.o_s1, model_s0(), model_s1());
                end
                checks++;
                if (bus.o_depth !== 4'(model_q.size())) begin
                    errors++;
                    $display("[TB] FAIL rand_depth: round %0d step %0d got %0d expected %0d",
                             round, n, bus.o_depth, model_q.size());
                end
                checks++;
                if (bus.o_overflow !== model_of || bus.o_underflow !== model_uf) begin
                    errors++;
                    $display("[TB] FAIL rand_flags: round %0d step %0d got of=%b uf=%b expected %b %b",
                             round, n, bus.o_overflow, bus.o_underflow, model_of, model_uf);
                end
            end
        end
    endtask

    initial begin
        bus.i_en   = 1'b0;
        bus.i_op   = OP_NONE;
        bus.i_data = '0;
        model_reset();
        test_reset();
        test_push_swap_over();
        test_alu_loop();
        test_underflow();
        test_overflow();
        test_async_reset();
        test_enable_low();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_stack.md
# data_stack

LIFO operand stack feeding the ALU. The top two entries are exposed as registered outputs `o_s0` (TOS) and `o_s1` (NOS), which connect directly to the ALU's `i_arg0` and `i_arg1`. The ALU's `o_data` returns through `i_data` with a replace-two operation, so a binary ALU op completes as "present args, wait one cycle, RPL2". Depth is bounded, and sticky overflow and underflow flags are reported to the controller.

## Interface
- `WIDTH`, default 8: bits per element; must match the ALU.
- `DEPTH`, default 12: maximum number of entries, ≥ 2.
- `i_clk`  in  1  system clock; all state changes on its rising edge.
- `i_rst_n`  in  1  reset; one clock, reset is asynchronous and active-low.
- `i_en`  in  1  perform `i_op` this cycle; when low the stack holds.
- `i_op`  in  3  stack operation: 0 NONE, 1 PUSH, 2 POP, 3 REPL, 4 SWAP, 5 DUP, 6 OVER, 7 RPL2.
- `i_data`  in  WIDTH  value for PUSH, REPL and RPL2.
- `o_s0`  out  WIDTH  top of stack; 0 when depth is 0.
- `o_s1`  out  WIDTH  next on stack; 0 when depth < 2.
- `o_depth`  out  clog2(DEPTH+1)  current entry count.
- `o_overflow`  out  1  sticky; set when an entry was lost off the bottom.
- `o_underflow`  out  1  sticky; set when an op needed more entries than present.

## Operation
- Storage:
  - TOS and NOS are held in dedicated registers.
  - Entries 2..DEPTH-1 are held in an array indexed by an internal pointer.
  - Any slot at or beyond the current depth reads as 0 on the outputs.
- Ops, with required depth d and resulting depth:
  - PUSH (any d): `i_data` becomes TOS and the old entries shift down; d+1.
  - POP (d ≥ 1): TOS is discarded; d-1.
  - REPL (d ≥ 1): TOS is replaced by `i_data`; d.
  - SWAP (d ≥ 2): TOS and NOS are exchanged; d.
  - DUP (d ≥ 1): a copy of TOS is pushed; d+1.
  - OVER (d ≥ 2): a copy of NOS is pushed; d+1.
  - RPL2 (d ≥ 2): TOS and NOS are removed and `i_data` is pushed; d-1.
  - NONE: no change.
- Underflow (d below the op's requirement):
  - The op is suppressed and all state is unchanged.
  - `o_underflow` is set.
- Overflow (PUSH, DUP or OVER at d == DEPTH):
  - The op is performed and the deepest entry is discarded.
  - Depth stays at DEPTH.
  - `o_overflow` is set.
- Both flags clear only on reset.
- When `i_en` is low, `i_op` is ignored entirely.
- Arithmetic: no width changes; values pass through unmodified.

## Timing
- Reset, asserted asynchronously: `o_s0`=0, `o_s1`=0, `o_depth`=0, `o_overflow`=0, `o_underflow`=0; array contents are don't-care.
- Release of `i_rst_n` is synchronised by the surrounding design; the first op may be issued on the first edge after release.
- All outputs are registered. An op sampled at edge k is reflected on every output immediately after edge k.
- Ops may issue back-to-back, one per cycle, with no bubbles.
- Binary ALU sequence:
  - Cycle k: `o_s0`/`o_s1` drive the ALU args, with ALU op selected.
  - Edge k+1: the ALU registers its result; the stack issues NONE, or an unrelated op that does not change TOS/NOS.
  - Cycle k+1: RPL2 with `i_data` = ALU `o_data`; the result is visible after edge k+2.
- Reset asserted mid-sequence: all state returns to the reset values immediately, regardless of the clock.

## Test plan
- Reset, then PUSH 0x11, 0x22, 0x33: after the 3rd edge `o_s0`=0x33, `o_s1`=0x22, `o_depth`=3; both flags 0.
- From that state, SWAP then OVER: `o_s0`=0x33, `o_s1`=0x22 after the OVER edge, with TOS/NOS order verified after each edge; `o_depth`=4.
- ALU loop with stack [0x05, 0x03] and ADD: after RPL2 with `i_data`=0x08, `o_s0`=0x08, `o_depth`=1; after POP `o_s0`=0, `o_depth`=0.
- Underflow: from empty, POP then RPL2: `o_depth` stays 0, `o_s0`=0, `o_underflow`=1 and remains 1 through a subsequent PUSH 0x44.
- Overflow: with DEPTH=12, PUSH 1..13: `o_depth`=12, `o_overflow`=1, `o_s0`=13; after 11 POPs `o_s0`=2 (entry 1 lost).
- Async reset asserted between edges with depth 5: all outputs become 0 before the next edge; `i_en` held high with PUSH during reset causes no change.
